// File: rtl/pc_sequencer.sv
// Instruction sequencer: FETCH/DECODE/EXEC/(MEM)/UPDATE schedule that issues exactly one PC
// command per instruction. Define JAL_LINK_EN to have JAL write the link register in EXEC.
module pc_sequencer #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instr,
  input  logic             instrValid,
  output logic             instrReady,
  input  logic             memDone,
  output logic             regWrite,
  output logic             flagWrite,
  output logic             memRead,
  output logic             memWrite,
  output logic [3:0]       rTargetSel,
  output logic             linkWrite,
  output logic [3:0]       linkSel,
  output logic             pcAdd,
  output logic             pcBranch,
  output logic             pcJump,
  output logic [3:0]       flagOp,
  output logic [WIDTH-1:0] immediate,
  output logic             illegalOp
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

`ifdef JAL_LINK_EN
  localparam bit LinkEn = 1'b1;
`else
  localparam bit LinkEn = 1'b0;
`endif

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StUpdate} state_e;
  typedef enum logic [2:0] {
    KindAlu, KindLoad, KindStor, KindBcond, KindJcond, KindJal, KindIllegal
  } kind_e;

  state_e           stateQ, stateD;
  kind_e            kindQ, kindD;
  logic [15:0]      instrQ;
  logic [CntW-1:0]  memCntQ, memCntD;
  logic [3:0]       flagOpQ, rTargetQ, linkSelQ;
  logic [WIDTH-1:0] immQ;

  assign flagOp     = flagOpQ;
  assign immediate  = immQ;
  assign rTargetSel = rTargetQ;
  assign linkSel    = linkSelQ;

  always_comb begin
    kindD = KindAlu;
    unique case (instrQ[15:12])
      4'b1100: kindD = KindBcond;
      4'b1111: kindD = KindIllegal;
      4'b0100: begin
        unique case (instrQ[7:4])
          4'b1100: kindD = KindJcond;
          4'b1000: kindD = KindJal;
          4'b0000: kindD = KindLoad;
          4'b0100: kindD = KindStor;
          default: kindD = KindIllegal;
        endcase
      end
      default: kindD = KindAlu;
    endcase
  end

  // Command fields are captured once in DECODE so they hold through UPDATE and the next FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ   <= StFetch;
      kindQ    <= KindAlu;
      instrQ   <= '0;
      memCntQ  <= '0;
      flagOpQ  <= '0;
      immQ     <= '0;
      rTargetQ <= '0;
      linkSelQ <= '0;
    end else begin
      stateQ  <= stateD;
      memCntQ <= memCntD;
      if (stateQ == StFetch && instrValid) begin
        instrQ <= instr;
      end
      if (stateQ == StDecode) begin
        kindQ    <= kindD;
        flagOpQ  <= (kindD == KindJal) ? 4'b1111 : instrQ[11:8];
        immQ     <= {{(WIDTH - 8){instrQ[7]}}, instrQ[7:0]};
        rTargetQ <= instrQ[3:0];
        linkSelQ <= instrQ[11:8];
      end
    end
  end

  always_comb begin
    stateD     = stateQ;
    memCntD    = memCntQ;
    instrReady = 1'b0;
    regWrite   = 1'b0;
    flagWrite  = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    linkWrite  = 1'b0;
    pcAdd      = 1'b0;
    pcBranch   = 1'b0;
    pcJump     = 1'b0;
    illegalOp  = 1'b0;
    unique case (stateQ)
      StFetch: begin
        instrReady = 1'b1;
        if (instrValid) stateD = StDecode;
      end
      StDecode: stateD = StExec;
      StExec: begin
        memCntD = '0;
        stateD  = StUpdate;
        unique case (kindQ)
          KindAlu: begin
            regWrite  = 1'b1;
            flagWrite = 1'b1;
          end
          KindLoad: begin
            memRead = 1'b1;
            stateD  = StMem;
          end
          KindStor: begin
            memWrite = 1'b1;
            stateD   = StMem;
          end
          KindJal:     linkWrite = LinkEn;
          KindIllegal: illegalOp = 1'b1;
          default: ;
        endcase
      end
      StMem: begin
        // The request drops in the completion cycle; LOAD writes back the returned data then.
        if (memDone) begin
          regWrite = (kindQ == KindLoad);
          stateD   = StUpdate;
        end else if (memCntQ == CntW'(MEM_TIMEOUT)) begin
          illegalOp = 1'b1;
          stateD    = StUpdate;
        end else begin
          memRead  = (kindQ == KindLoad);
          memWrite = (kindQ == KindStor);
          memCntD  = memCntQ + CntW'(1);
        end
      end
      StUpdate: begin
        stateD = StFetch;
        unique case (kindQ)
          KindBcond:         pcBranch = 1'b1;
          KindJcond, KindJal: pcJump  = 1'b1;
          default:           pcAdd    = 1'b1;
        endcase
      end
      default: stateD = StFetch;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues expected per-instruction summaries, a
// negedge monitor accumulates enables per instruction and compares at each PC command.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instr = 16'hFFFF;
  logic        instrValid = 1'b0;
  logic        instrReady;
  logic        memDone = 1'b0;
  logic        regWrite, flagWrite, memRead, memWrite;
  logic [3:0]  rTargetSel;
  logic        linkWrite;
  logic [3:0]  linkSel;
  logic        pcAdd, pcBranch, pcJump;
  logic [3:0]  flagOp;
  logic [15:0] immediate;
  logic        illegalOp;

  pc_sequencer #(.WIDTH(16), .MEM_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instrValid(instrValid),
    .instrReady(instrReady), .memDone(memDone), .regWrite(regWrite),
    .flagWrite(flagWrite), .memRead(memRead), .memWrite(memWrite),
    .rTargetSel(rTargetSel), .linkWrite(linkWrite), .linkSel(linkSel),
    .pcAdd(pcAdd), .pcBranch(pcBranch), .pcJump(pcJump), .flagOp(flagOp),
    .immediate(immediate), .illegalOp(illegalOp)
  );

  always #5 clk = ~clk;

`ifdef JAL_LINK_EN
  localparam int LinkExp = 1;
`else
  localparam int LinkExp = 0;
`endif

  localparam logic [2:0] CmdAdd = 3'b001;
  localparam logic [2:0] CmdBr  = 3'b010;
  localparam logic [2:0] CmdJmp = 3'b100;

  typedef struct {
    string       name;
    logic [2:0]  cmd;
    int          lat, rw, fw, mr, mw, ill, lk;
    bit          chkF, chkI, chkR;
    logic [3:0]  flag;
    logic [15:0] imm;
    logic [3:0]  rt;
    logic [3:0]  ls;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input logic [2:0] cmd, input int lat, input int rw,
                      input int fw, input int mr, input int mw, input int ill, input int lk,
                      input bit chkF, input logic [3:0] flag, input bit chkI,
                      input logic [15:0] imm, input bit chkR, input logic [3:0] rt,
                      input logic [3:0] ls);
    exp_t e;
    e.name = name; e.cmd = cmd; e.lat = lat; e.rw = rw; e.fw = fw; e.mr = mr; e.mw = mw;
    e.ill = ill; e.lk = lk; e.chkF = chkF; e.flag = flag; e.chkI = chkI; e.imm = imm;
    e.chkR = chkR; e.rt = rt; e.ls = ls;
    expQ.push_back(e);
  endtask

  // Memory responder: raises memDone in the memDelay-th MEM cycle (0 = never).
  int   memDelay = 0;
  int   enCnt = 0;
  logic memDoneNext = 1'b0;
  always @(negedge clk) begin
    if (!reset) enCnt = 0;
    else if (memRead || memWrite) enCnt++;
    else enCnt = 0;
    memDoneNext = (memDelay > 0) && (enCnt == memDelay);
  end
  always @(posedge clk) begin
    #1;
    memDone = memDoneNext;
  end

  // Monitor
  int cyc = 0, acceptCyc = 0;
  int rw = 0, fw = 0, mr = 0, mw = 0, ill = 0, lk = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      cyc++;
      if (instrReady && instrValid) begin
        acceptCyc = cyc;
        rw = 0; fw = 0; mr = 0; mw = 0; ill = 0; lk = 0;
      end
      rw += regWrite ? 1 : 0;
      fw += flagWrite ? 1 : 0;
      mr += memRead ? 1 : 0;
      mw += memWrite ? 1 : 0;
      ill += illegalOp ? 1 : 0;
      lk += linkWrite ? 1 : 0;
      if (linkWrite) begin
        if (expQ.size() == 0) chk("linkWrite-unexpected", 1, 0);
        else chk({expQ[0].name, ".linkSel"}, linkSel, expQ[0].ls);
      end
      if (pcAdd || pcBranch || pcJump) begin
        if (expQ.size() == 0) begin
          chk("pc-cmd-unexpected", {pcJump, pcBranch, pcAdd}, 0);
        end else begin
          e = expQ.pop_front();
          chk({e.name, ".cmd"}, {pcJump, pcBranch, pcAdd}, e.cmd);
          chk({e.name, ".latency"}, cyc - acceptCyc, e.lat);
          chk({e.name, ".regWrite"}, rw, e.rw);
          chk({e.name, ".flagWrite"}, fw, e.fw);
          chk({e.name, ".memRead"}, mr, e.mr);
          chk({e.name, ".memWrite"}, mw, e.mw);
          chk({e.name, ".illegalOp"}, ill, e.ill);
          chk({e.name, ".linkWrite"}, lk, e.lk);
          if (e.chkF) chk({e.name, ".flagOp"}, flagOp, e.flag);
          if (e.chkI) chk({e.name, ".immediate"}, immediate, e.imm);
          if (e.chkR) chk({e.name, ".rTargetSel"}, rTargetSel, e.rt);
        end
      end
    end
  end

  task automatic finishRun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Drives instr at posedge+1; returns just after the accepting edge.
  task automatic issue(input logic [15:0] w, input bit keep);
    int n;
    instr = w;
    instrValid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!instrReady && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!instrReady) begin
      errors++;
      $display("FAIL accept-timeout: instrReady=%0b, expected 1", instrReady);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "sequencer never returned to FETCH");
    end
    @(posedge clk);
    #1;
    if (!keep) begin
      instrValid = 1'b0;
      instr = 16'hFFFF;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (expQ.size() > 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({name, ".pending"}, expQ.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string name);
    chk({name, ".instrReady"}, instrReady, 1);
    chk({name, ".enables"}, {regWrite, flagWrite, memRead, memWrite, linkWrite, illegalOp}, 0);
    chk({name, ".pcCmd"}, {pcJump, pcBranch, pcAdd}, 0);
    chk({name, ".fields"}, {flagOp, immediate, rTargetSel, linkSel}, 0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkIdle("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;

    push("alu0123", CmdAdd, 3, 1, 1, 0, 0, 0, 0, 0, 4'h0, 0, 16'h0, 0, 4'h0, 4'h0);
    issue(16'h0123, 0);
    push("bccC0FE", CmdBr, 3, 0, 0, 0, 0, 0, 0, 1, 4'h0, 1, 16'hFFFE, 0, 4'h0, 4'h0);
    issue(16'hC0FE, 0);
    push("bccC180", CmdBr, 3, 0, 0, 0, 0, 0, 0, 1, 4'h1, 1, 16'hFF80, 0, 4'h0, 4'h0);
    issue(16'hC180, 0);
    // instrValid held high across the branch; the next word is only taken at the next FETCH
    push("bccC57F", CmdBr, 3, 0, 0, 0, 0, 0, 0, 1, 4'h5, 1, 16'h007F, 0, 4'h0, 4'h0);
    issue(16'hC57F, 1);
    push("jcc4AC9", CmdJmp, 3, 0, 0, 0, 0, 0, 0, 1, 4'hA, 0, 16'h0, 1, 4'h9, 4'h0);
    issue(16'h4AC9, 0);
    push("jcc4EC5", CmdJmp, 3, 0, 0, 0, 0, 0, 0, 1, 4'hE, 0, 16'h0, 1, 4'h5, 4'h0);
    issue(16'h4EC5, 0);
    push("jal4F83", CmdJmp, 3, 0, 0, 0, 0, 0, LinkExp, 1, 4'hF, 0, 16'h0, 1, 4'h3, 4'hF);
    issue(16'h4F83, 0);
    push("aluD000", CmdAdd, 3, 1, 1, 0, 0, 0, 0, 0, 4'h0, 0, 16'h0, 0, 4'h0, 4'h0);
    issue(16'hD000, 0);
    drain("branches");

    memDelay = 4;
    push("load4", CmdAdd, 7, 1, 0, 4, 0, 0, 0, 0, 4'h0, 0, 16'h0, 0, 4'h0, 4'h0);
    issue(16'h4201, 0);
    drain("load4");
    memDelay = 1;
    push("load1", CmdAdd, 4, 1, 0, 1, 0, 0, 0, 0, 4'h0, 0, 16'h0, 0, 4'h0, 4'h0);
    issue(16'h4301, 0);
    drain("load1");
    memDelay = 2;
    push("stor2", CmdAdd, 5, 0, 0, 0, 2, 0, 0, 0, 4'h0, 0, 16'h0, 0, 4'h0, 4'h0);
    issue(16'h4345, 0);
    drain("stor2");
    memDelay = 0;
    push("storTimeout", CmdAdd, 259, 0, 0, 0, 256, 1, 0, 0, 4'h0, 0, 16'h0, 0, 4'h0, 4'h0);
    issue(16'h4045, 0);
    drain("storTimeout");

    push("illF000", CmdAdd, 3, 0, 0, 0, 0, 1, 0, 0, 4'h0, 0, 16'h0, 0, 4'h0, 4'h0);
    issue(16'hF000, 0);
    push("ill4010", CmdAdd, 3, 0, 0, 0, 0, 1, 0, 0, 4'h0, 0, 16'h0, 0, 4'h0, 4'h0);
    issue(16'h4010, 0);
    drain("illegal");

    // Reset in the first MEM cycle of a LOAD: no PC command may follow.
    memDelay = 0;
    issue(16'h4201, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("midMem.memRead", memRead, 1);
    #2;
    reset = 1'b0;
    #1;
    checkIdle("midMemReset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    push("aluAfterReset", CmdAdd, 3, 1, 1, 0, 0, 0, 0, 0, 4'h0, 0, 16'h0, 0, 4'h0, 4'h0);
    issue(16'h0123, 0);
    drain("afterReset");

    finishRun();
  end

endmodule
